// File: rtl/key_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, column
// classification and default timing constants for a 50 MHz clock.
package key_scan_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    PRESS_DEB = 2'd1,
    HOLD      = 2'd2,
    REL_DEB   = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    COL_IDLE   = 2'd0,
    COL_SINGLE = 2'd1,
    COL_MULTI  = 2'd2
  } col_class_e;

  localparam logic [16:0] MS_MAX_DEF = 17'd49999;
  localparam logic [7:0]  DEB_MS_DEF = 8'd20;

  function automatic col_class_e classify_cols(input logic [3:0] cols);
    logic [2:0] lows;
    lows = 3'd0;
    for (int i = 0; i < 4; i++) lows = lows + {2'b00, ~cols[i]};
    if (lows == 3'd0)      return COL_IDLE;
    else if (lows == 3'd1) return COL_SINGLE;
    else                   return COL_MULTI;
  endfunction

  // Index of the lowest-numbered low column; only meaningful for a single press.
  function automatic logic [1:0] low_col(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (!cols[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/tick_1ms.sv
// Free-running 1 ms timebase: a registered one-clock tick every MS_MAX+1 clocks.
module tick_1ms
  import key_scan_pkg::*;
#(
  parameter logic [16:0] MS_MAX = MS_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [16:0] cnt_1ms;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_1ms <= 17'd0;
      tick    <= 1'b0;
    end else begin
      tick <= (cnt_1ms == MS_MAX);
      if (cnt_1ms == MS_MAX) cnt_1ms <= 17'd0;
      else                   cnt_1ms <= cnt_1ms + 17'd1;
    end
  end

endmodule

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: walks the rows on a 1 ms tick, debounces press and
// release, and reports each accepted key once with a one-clock strobe.
module key_scan
  import key_scan_pkg::*;
#(
  parameter logic [16:0] MS_MAX = MS_MAX_DEF,
  parameter logic [7:0]  DEB_MS = DEB_MS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_vld,
  output logic       key_down
);

  logic        tick;
  logic [3:0]  col_meta;
  logic [3:0]  col_s;
  logic [3:0]  col_pat;
  logic [1:0]  row_idx;
  logic [1:0]  col_idx;
  logic [7:0]  deb_cnt;
  scan_state_e state;
  col_class_e  col_cls;

  tick_1ms #(.MS_MAX(MS_MAX)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'b1111;
      col_s    <= 4'b1111;
    end else begin
      col_meta <= col_n;
      col_s    <= col_meta;
    end
  end

  assign col_cls = classify_cols(col_s);

  // row_idx tracks row_n so the scanned row is already latched when a press is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SCAN;
      row_n    <= 4'b1110;
      row_idx  <= 2'd0;
      col_idx  <= 2'd0;
      col_pat  <= 4'b1111;
      deb_cnt  <= 8'd0;
      key_code <= 4'd0;
      key_vld  <= 1'b0;
      key_down <= 1'b0;
    end else begin
      key_vld <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (col_cls == COL_SINGLE) begin
              col_pat <= col_s;
              col_idx <= low_col(col_s);
              deb_cnt <= 8'd0;
              state   <= PRESS_DEB;
            end else begin
              row_n   <= {row_n[2:0], row_n[3]};
              row_idx <= row_idx + 2'd1;
            end
          end
          PRESS_DEB: begin
            if (col_s == col_pat) begin
              if (deb_cnt + 8'd1 == DEB_MS) begin
                key_vld  <= 1'b1;
                key_code <= {row_idx, col_idx};
                key_down <= 1'b1;
                deb_cnt  <= 8'd0;
                state    <= HOLD;
              end else begin
                deb_cnt <= deb_cnt + 8'd1;
              end
            end else begin
              deb_cnt <= 8'd0;
              state   <= SCAN;
            end
          end
          HOLD: begin
            if (col_cls == COL_IDLE) begin
              deb_cnt <= 8'd0;
              state   <= REL_DEB;
            end
          end
          REL_DEB: begin
            if (col_cls == COL_IDLE) begin
              if (deb_cnt + 8'd1 == DEB_MS) begin
                key_down <= 1'b0;
                deb_cnt  <= 8'd0;
                row_n    <= {row_n[2:0], row_n[3]};
                row_idx  <= row_idx + 2'd1;
                state    <= SCAN;
              end else begin
                deb_cnt <= deb_cnt + 8'd1;
              end
            end else begin
              state <= HOLD;
            end
          end
          default: begin
            state    <= SCAN;
            row_n    <= 4'b1110;
            row_idx  <= 2'd0;
            col_idx  <= 2'd0;
            col_pat  <= 4'b1111;
            deb_cnt  <= 8'd0;
            key_code <= 4'd0;
            key_down <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: an emulated 4x4 keypad drives the columns, and a
// keypad-level reference model predicts row drive, key code and strobes per tick.
module tb_key_scan;

  localparam int TICK_CLKS = 10;
  localparam int DEB       = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_vld;
  logic        key_down;
  logic [15:0] keys;

  int tests = 0;
  int fails = 0;
  int vld_seen = 0;

  int m_row, m_code, m_vld, m_pcol, m_run, m_idle;
  bit m_down, m_armed, m_rel, m_pulse;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  row_n;
    logic [3:0]  code;
    logic        down;
    logic        vld;
  } vec_t;

  vec_t vecs[21];

  key_scan #(.MS_MAX(17'd9), .DEB_MS(8'd3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .col_n   (col_n),
    .row_n   (row_n),
    .key_code(key_code),
    .key_vld (key_vld),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  // A held key at (r,c) pulls column c low whenever row r is driven low.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!row_n[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) if (key_vld) vld_seen++;

  task automatic model_reset();
    m_row = 0; m_code = 0; m_down = 0; m_armed = 0; m_rel = 0; m_pulse = 0;
    m_run = 0; m_idle = 0;
  endtask

  // One scan tick in keypad terms: which columns of the current row are pressed.
  task automatic model_tick();
    logic [3:0] low;
    low = keys[m_row*4 +: 4];
    m_pulse = 0;
    if (m_down) begin
      if (low == 4'b0000) begin
        if (!m_rel) begin
          m_rel = 1; m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == DEB) begin
            m_down = 0; m_rel = 0; m_row = (m_row + 1) % 4;
          end
        end
      end else begin
        m_rel = 0;
      end
    end else if (m_armed) begin
      if (low == (4'b0001 << m_pcol)) begin
        m_run++;
        if (m_run == DEB) begin
          m_armed = 0; m_down = 1; m_code = m_row*4 + m_pcol; m_vld++; m_pulse = 1;
        end
      end else begin
        m_armed = 0;
      end
    end else if ($countones(low) == 1) begin
      m_armed = 1; m_run = 0;
      for (int c = 0; c < 4; c++) if (low[c]) m_pcol = c;
    end else begin
      m_row = (m_row + 1) % 4;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the given keys through one tick, then sample just past the next falling edge.
  task automatic applyStimulus(input logic [15:0] k);
    keys = k;
    repeat (TICK_CLKS) @(posedge clk);
    #6;
    model_tick();
  endtask

  task automatic check_model(input string tag);
    logic [3:0] er;
    logic [3:0] ec;
    er = ~(4'b0001 << m_row);
    ec = 4'(m_code);
    checkOutput({tag, ".row_n"}, 32'(row_n), 32'(er));
    checkOutput({tag, ".key_code"}, 32'(key_code), 32'(ec));
    checkOutput({tag, ".key_down"}, 32'(key_down), 32'(m_down));
    checkOutput({tag, ".key_vld"}, 32'(key_vld), 32'(m_pulse));
    checkOutput({tag, ".vld_count"}, 32'(vld_seen), 32'(m_vld));
  endtask

  task automatic run_ticks(input logic [15:0] k, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(k);
      check_model(tag);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, ".row_n"}, 32'(row_n), 32'(4'b1110));
    checkOutput({tag, ".key_code"}, 32'(key_code), 32'(4'h0));
    checkOutput({tag, ".key_vld"}, 32'(key_vld), 32'(1'b0));
    checkOutput({tag, ".key_down"}, 32'(key_down), 32'(1'b0));
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check_reset_values(tag);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
  endtask

  initial begin
    int vld_before;
    logic [15:0] rk;
    logic [3:0] ec;

    for (int i = 0; i < 21; i++) vecs[i] = '{16'h0000, 4'b1011, 4'h0, 1'b0, 1'b0};
    vecs[0].row_n = 4'b1101;
    vecs[1].row_n = 4'b1011;
    vecs[2].row_n = 4'b0111;
    vecs[3].row_n = 4'b1110;
    vecs[4].row_n = 4'b1101;
    for (int i = 6; i < 16; i++) vecs[i].keys = 16'h0200;
    for (int i = 9; i < 21; i++) vecs[i].code = 4'h9;
    for (int i = 9; i < 19; i++) vecs[i].down = 1'b1;
    vecs[9].vld    = 1'b1;
    vecs[19].row_n = 4'b0111;
    vecs[20].row_n = 4'b1110;

    keys  = 16'h0000;
    m_vld = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Idle rotation, then a clean press at row 2 col 1 held 10 ticks and released.
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].keys);
      checkOutput($sformatf("vec%0d.row_n", i), 32'(row_n), 32'(vecs[i].row_n));
      checkOutput($sformatf("vec%0d.key_code", i), 32'(key_code), 32'(vecs[i].code));
      checkOutput($sformatf("vec%0d.key_down", i), 32'(key_down), 32'(vecs[i].down));
      checkOutput($sformatf("vec%0d.key_vld", i), 32'(key_vld), 32'(vecs[i].vld));
    end
    checkOutput("table.vld_count", 32'(vld_seen), 32'd1);

    // Press bounce on row 0 col 3.
    run_ticks(16'h0008, 1, "bounce");
    run_ticks(16'h0000, 1, "bounce");
    run_ticks(16'h0008, 3, "bounce");
    checkOutput("bounce.no_early_vld", 32'(vld_seen), 32'd1);
    run_ticks(16'h0008, 1, "bounce");
    checkOutput("bounce.key_code", 32'(key_code), 32'(4'h3));
    checkOutput("bounce.vld_count", 32'(vld_seen), 32'd2);

    // Release bounce: idle, pressed, then clean idle.
    run_ticks(16'h0008, 2, "relbounce");
    run_ticks(16'h0000, 1, "relbounce");
    run_ticks(16'h0008, 1, "relbounce");
    run_ticks(16'h0000, 3, "relbounce");
    checkOutput("relbounce.down_held", 32'(key_down), 32'd1);
    run_ticks(16'h0000, 1, "relbounce");
    checkOutput("relbounce.down_fall", 32'(key_down), 32'd0);
    checkOutput("relbounce.vld_count", 32'(vld_seen), 32'd2);

    // Two columns on row 1 are a multi-press; dropping one leaves a single key.
    run_ticks(16'h0050, 8, "multi");
    checkOutput("multi.vld_count", 32'(vld_seen), 32'd2);
    run_ticks(16'h0010, 8, "multi");
    checkOutput("multi.key_code", 32'(key_code), 32'(4'h4));
    run_ticks(16'h0000, 5, "multi");

    // Reset in the middle of press debounce, key kept held across reset.
    rk = 16'h0000;
    rk[m_row*4 + 2] = 1'b1;
    ec = 4'(m_row*4 + 2);
    vld_before = vld_seen;
    run_ticks(rk, 3, "rstdeb");
    pulse_reset("rstdeb.reset");
    checkOutput("rstdeb.no_vld", 32'(vld_seen), 32'(vld_before));
    run_ticks(rk, 8, "rstdeb");
    checkOutput("rstdeb.key_code", 32'(key_code), 32'(ec));
    checkOutput("rstdeb.vld_count", 32'(vld_seen), 32'(vld_before + 1));
    run_ticks(16'h0000, 5, "rstdeb");

    // Random key activity against the model.
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        rk = 16'h0000;
        case ($urandom_range(0, 2))
          0: rk = 16'h0000;
          1: rk[$urandom_range(0, 15)] = 1'b1;
          default: begin
            rk[$urandom_range(0, 15)] = 1'b1;
            rk[$urandom_range(0, 15)] = 1'b1;
          end
        endcase
        keys = rk;
      end
      applyStimulus(keys);
      check_model("random");
    end
    run_ticks(16'h0000, 6, "final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
- 4x4 matrix keypad scanner; the input-side counterpart of the multiplexed seven-segment display driver.
- Drives one keypad row low at a time and samples the four column lines.
- Debounces press and release, then emits a 4-bit key code with a one-clock valid strobe.
- Feeds the second-counter control logic (set/start/stop/clear) in the same 50 MHz clock domain.

Parameters:
- MS_MAX, 17'd49999: terminal count of the 1 ms tick counter (50 MHz clock). Benches override it small.
- DEB_MS, 8'd20: debounce interval in 1 ms ticks, applied to both press and release. Legal range 1..255.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- col_n  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk.
- row_n  output  4  keypad row drive, active-low one-hot.
- key_code  output  4  code of the last accepted key, {row[1:0], col[1:0]}, held until the next accept.
- key_vld  output  1  one-clock pulse when a debounced press is accepted.
- key_down  output  1  high from accept until the debounced release completes.

Behaviour:
- Reset (async, rst_n low):
  - row_n=4'b1110 (row 0), key_code=0, key_vld=0, key_down=0.
  - FSM=SCAN; tick counter and debounce counter cleared.
- Input synchronisation:
  - col_n passes through a 2-flop synchroniser giving col_s.
  - All decisions use col_s, sampled only on tick cycles.
- Tick generation:
  - cnt_1ms counts 0..MS_MAX and wraps.
  - tick is registered and is high for exactly one clk after cnt_1ms==MS_MAX. Period is MS_MAX+1 clocks.
- col_s is classified as one of:
  - idle: 4'b1111.
  - single: exactly one bit low.
  - multi: two or more bits low.
- FSM states: SCAN, PRESS_DEB, HOLD, REL_DEB. Nothing changes on non-tick cycles except that key_vld clears.
- SCAN, on tick:
  - single: latch row index and column index, clear deb_cnt, go PRESS_DEB. row_n is not advanced.
  - idle or multi: rotate row_n to the next row (row 3 wraps to row 0).
- PRESS_DEB, on tick:
  - col_s equals the latched pattern: deb_cnt++.
  - On reaching DEB_MS: assert key_vld for 1 clk, load key_code={row_idx, col_idx}, set key_down=1, go HOLD.
  - Any other col_s: clear deb_cnt and go SCAN. The row is held and rescanned on the next tick.
- HOLD, on tick:
  - col_s==4'b1111: clear deb_cnt, go REL_DEB.
  - Otherwise stay in HOLD. Additional keys are ignored and row_n stays held.
- REL_DEB, on tick:
  - col_s idle: deb_cnt++. On reaching DEB_MS: key_down=0, rotate row_n, go SCAN.
  - Any low column: go HOLD with key_down still 1.
- Timing:
  - Accept latency: DEB_MS ticks after the first tick that sees the press.
  - key_vld rises in the clock after that tick.
- Auto-repeat: none. One key_vld per press.
- Reset asserted mid-debounce or mid-hold: immediate return to reset values and no key_vld. After release of rst_n, scanning restarts at row 0.
- Illegal FSM encodings recover to SCAN with reset output values.

Decomposition:
- Shared package holds:
  - state encodings for SCAN, PRESS_DEB, HOLD, REL_DEB;
  - the default 1 ms terminal count;
  - the default debounce count.
- One sub-module: tick_1ms.
  - Parameter: MS_MAX.
  - Ports: clk, rst_n, tick.
  - The display driver's refresh counter is intended to be migrated onto it later.
- Synchroniser and FSM stay in key_scan.

Test Plan (MS_MAX=9, DEB_MS=3, so 10-clock ticks):
- Idle, no keys: row_n cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step per tick. key_vld never asserts.
- Key at row 2, col 1, pressed clean and held 10 ticks: exactly one key_vld pulse.
  - key_code=4'b1001.
  - key_down=1 from the pulse until 3 idle ticks after release.
  - row_n stays 1011 throughout.
- Bounce, press at row 0 col 3 for 1 tick, release 1 tick, then stable: no key_vld for the glitch.
  - Single accept with key_code=4'b0011 three ticks after the stable press.
- Release bounce, key held, then released 1 tick, low 1 tick, then idle: key_down stays 1 through the bounce.
  - key_down falls only after 3 consecutive idle ticks.
  - No second key_vld.
- Two columns (col 0 and col 2) low on row 1 simultaneously: treated as multi.
  - Scanning continues and no key_vld.
  - Releasing col 2 leaves col 0; accept gives key_code=4'b0100.
- rst_n pulsed low during PRESS_DEB (deb_cnt=2): outputs return to reset values immediately and no key_vld.
  - With the key still held after reset release, accept comes DEB_MS ticks after rescan reaches its row.
